// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [31:0] LoadData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;

  // Requester plus data memory: issues requests and returns read words.
  modport master (
    output Start, Op, Address, StoreData, MemReadData,
    input  Busy, Done, Error, LoadData, MemRead, MemWrite, MemAddress, MemWriteData
  );

  // Load/store unit side.
  modport slave (
    input  Start, Op, Address, StoreData, MemReadData,
    output Busy, Done, Error, LoadData, MemRead, MemWrite, MemAddress, MemWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads with sign/zero extension, word stores
// and read-modify-write sub-word stores against a 64-word data memory.
module load_store_unit (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned WIDX_W = 6;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_STORE    = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e              state_q,     state_d;
  logic [1:0]          size_q,      size_d;
  logic                unsigned_q,  unsigned_d;
  logic [1:0]          offset_q,    offset_d;
  logic [WIDX_W-1:0]   widx_q,      widx_d;
  logic [HALF_W-1:0]   sdata_q,     sdata_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                error_q,     error_d;
  logic [DW-1:0]       load_data_q, load_data_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [AW-1:0]       mem_addr_q,  mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;

  logic                req_illegal;
  logic                req_store;

  // Pick the addressed lane of a little-endian word and extend it to 32 bits.
  function automatic logic [DW-1:0] extract_lane(input logic [DW-1:0] word,
                                                 input logic [1:0]    size,
                                                 input logic [1:0]    off,
                                                 input logic          is_unsigned);
    logic [DW-1:0] shifted;
    logic [DW-1:0] result;
    shifted = word >> {off, 3'b000};
    unique case (size)
      SZ_BYTE: result = is_unsigned
                        ? {{(DW-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]}
                        : {{(DW-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
      SZ_HALF: result = is_unsigned
                        ? {{(DW-HALF_W){1'b0}}, shifted[HALF_W-1:0]}
                        : {{(DW-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replace the addressed byte or half of a word with new store data.
  function automatic logic [DW-1:0] merge_lane(input logic [DW-1:0]     word,
                                               input logic [HALF_W-1:0] data,
                                               input logic [1:0]        size,
                                               input logic [1:0]        off);
    logic [DW-1:0] mask;
    logic [DW-1:0] ins;
    if (size == SZ_HALF) begin
      mask = {{(DW-HALF_W){1'b0}}, {HALF_W{1'b1}}} << {off, 3'b000};
      ins  = {{(DW-HALF_W){1'b0}}, data} << {off, 3'b000};
    end else begin
      mask = {{(DW-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << {off, 3'b000};
      ins  = {{(DW-BYTE_W){1'b0}}, data[BYTE_W-1:0]} << {off, 3'b000};
    end
    return (word & ~mask) | (ins & mask);
  endfunction

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    req_store   = bus.Op[3];
    req_illegal = 1'b0;
    unique case (bus.Op[1:0])
      SZ_BYTE: req_illegal = 1'b0;
      SZ_HALF: req_illegal = bus.Address[0];
      SZ_WORD: req_illegal = (bus.Address[1:0] != 2'b00);
      SZ_BAD:  req_illegal = 1'b1;
      default: req_illegal = 1'b1;
    endcase
    if (bus.Address[AW-1:8] != '0) begin
      req_illegal = 1'b1;
    end
  end

  // Next state, latched request fields and next values of registered outputs.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    offset_d    = offset_q;
    widx_d      = widx_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    error_d     = 1'b0;
    mem_wdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          size_d     = bus.Op[1:0];
          unsigned_d = bus.Op[2];
          offset_d   = bus.Address[1:0];
          widx_d     = bus.Address[7:2];
          sdata_d    = bus.StoreData[HALF_W-1:0];
          if (req_illegal) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end else if (!req_store) begin
            state_d = S_LOAD;
          end else if (bus.Op[1:0] == SZ_WORD) begin
            state_d     = S_STORE;
            mem_wdata_d = bus.StoreData;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        load_data_d = extract_lane(bus.MemReadData, size_q, offset_q, unsigned_q);
        state_d     = S_DONE;
      end
      S_RMW_READ: begin
        mem_wdata_d = merge_lane(bus.MemReadData, sdata_q, size_q, offset_q);
        state_d     = S_STORE;
      end
      S_STORE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are clean flop outputs.
    busy_d      = (state_d == S_LOAD) || (state_d == S_RMW_READ) || (state_d == S_STORE);
    mem_read_d  = (state_d == S_LOAD) || (state_d == S_RMW_READ);
    mem_write_d = (state_d == S_STORE);
    done_d      = (state_d == S_DONE);
    mem_addr_d  = (mem_read_d || mem_write_d) ? {{(AW-WIDX_W){1'b0}}, widx_d} : '0;
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      offset_q    <= '0;
      widx_q      <= '0;
      sdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      load_data_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      offset_q    <= offset_d;
      widx_q      <= widx_d;
      sdata_q     <= sdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      load_data_q <= load_data_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Error        = error_q;
  assign bus.LoadData     = load_data_q;
  assign bus.MemRead      = mem_read_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemWriteData = mem_wdata_q;

endmodule
